// File: rtl/timing_counter_tracker.sv
// Per-bank DRAM command timing counters (cycles until PRE/ACT/CASRD/CASWR may issue).
// Optional per-rank four-activate-window tracker is built when TFAW_TRACK_EN is defined.
`ifndef PRE
`define PRE    3'd0
`endif
`ifndef ACT
`define ACT    3'd1
`endif
`ifndef CASRD
`define CASRD  3'd2
`endif
`ifndef CASRDA
`define CASRDA 3'd3
`endif
`ifndef CASWR
`define CASWR  3'd4
`endif
`ifndef CASWRA
`define CASWRA 3'd5
`endif

module timing_counter_tracker #(
    parameter int NUM_BNK_TOT    = 1,
    parameter int NUM_RNK_TOT    = 1,
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int TIME_WIDTH     = 16,
    localparam int BANK_W        = (NUM_BNK_TOT > 1) ? $clog2(NUM_BNK_TOT) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          issue_valid,
    input  logic [CMD_TYPE_WIDTH-1:0]                     issue_cmd,
    input  logic [BANK_W-1:0]                             issue_bank,
    input  logic [TIME_WIDTH-1:0]                         t_rp,
    input  logic [TIME_WIDTH-1:0]                         t_rcd,
    input  logic [TIME_WIDTH-1:0]                         t_ras,
    input  logic [TIME_WIDTH-1:0]                         t_rc,
    input  logic [TIME_WIDTH-1:0]                         t_rrd,
    input  logic [TIME_WIDTH-1:0]                         t_rtp,
    input  logic [TIME_WIDTH-1:0]                         t_wr,
    input  logic [TIME_WIDTH-1:0]                         t_ccd,
    input  logic [TIME_WIDTH-1:0]                         t_rtw,
    input  logic [TIME_WIDTH-1:0]                         t_wtr,
    input  logic [TIME_WIDTH-1:0]                         t_faw,
    output logic [NUM_BNK_TOT-1:0][3:0][TIME_WIDTH-1:0]   cmd_counter,
    output logic [NUM_RNK_TOT-1:0][TIME_WIDTH-1:0]        tfaw_counter,
    output logic [NUM_RNK_TOT-1:0]                        tfaw_valid
);

    localparam int BPR    = NUM_BNK_TOT / NUM_RNK_TOT;
    localparam int RANK_W = (NUM_RNK_TOT > 1) ? $clog2(NUM_RNK_TOT) : 1;
    localparam int I_PRE  = 0;
    localparam int I_ACT  = 1;
    localparam int I_RD   = 2;
    localparam int I_WR   = 3;

    typedef logic [TIME_WIDTH-1:0] time_t;

    function automatic time_t max_t(input time_t a, input time_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic time_t dec_t(input time_t a);
        return (a == '0) ? '0 : a - time_t'(1);
    endfunction

    function automatic time_t sat_sum(input time_t a, input time_t b);
        logic [TIME_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TIME_WIDTH] ? '1 : s[TIME_WIDTH-1:0];
    endfunction

    logic              bank_ok;
    logic              issue_ok;
    logic              cmd_pre, cmd_act, cmd_rd, cmd_rda, cmd_wr, cmd_wra;
    logic [RANK_W-1:0] issue_rank;
    time_t             rd_to_wr, wr_to_rd, rda_to_act, wra_to_act;

    // Out-of-range banks and unknown codes simply decode to no command.
    assign bank_ok  = ({1'b0, issue_bank} < (BANK_W+1)'(NUM_BNK_TOT));
    assign issue_ok = issue_valid && bank_ok;
    assign cmd_pre  = issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`PRE));
    assign cmd_act  = issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`ACT));
    assign cmd_rda  = issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`CASRDA));
    assign cmd_rd   = cmd_rda || (issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`CASRD)));
    assign cmd_wra  = issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`CASWRA));
    assign cmd_wr   = cmd_wra || (issue_ok && (issue_cmd == CMD_TYPE_WIDTH'(`CASWR)));

    assign issue_rank = RANK_W'(32'(issue_bank) / BPR);
    assign rd_to_wr   = max_t(t_ccd, t_rtw);
    assign wr_to_rd   = max_t(t_ccd, t_wtr);
    assign rda_to_act = sat_sum(t_rtp, t_rp);
    assign wra_to_act = sat_sum(t_wr, t_rp);

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_BNK_TOT; gi++) begin : g_bank
            localparam logic [RANK_W-1:0] MY_RANK = RANK_W'(gi / BPR);

            logic                         this_bank;
            logic                         same_rank;
            logic [3:0][TIME_WIDTH-1:0]   cons;
            logic [3:0][TIME_WIDTH-1:0]   cnt_q, cnt_d;

            assign this_bank = (issue_bank == BANK_W'(gi));
            assign same_rank = (issue_rank == MY_RANK);

            // A zero constraint means "no update": the counter keeps decrementing.
            always_comb begin
                cons = '0;
                if (this_bank) begin
                    if (cmd_pre) cons[I_ACT] = t_rp;
                    if (cmd_act) begin
                        cons[I_RD]  = t_rcd;
                        cons[I_WR]  = t_rcd;
                        cons[I_PRE] = t_ras;
                        cons[I_ACT] = t_rc;
                    end
                    if (cmd_rd)  cons[I_PRE] = t_rtp;
                    if (cmd_rda) cons[I_ACT] = rda_to_act;
                    if (cmd_wr)  cons[I_PRE] = t_wr;
                    if (cmd_wra) cons[I_ACT] = wra_to_act;
                end
                if (same_rank) begin
                    if (cmd_act && !this_bank) cons[I_ACT] = t_rrd;
                    if (cmd_rd) begin
                        cons[I_RD] = t_ccd;
                        cons[I_WR] = rd_to_wr;
                    end
                    if (cmd_wr) begin
                        cons[I_WR] = t_ccd;
                        cons[I_RD] = wr_to_rd;
                    end
                end
            end

            for (gk = 0; gk < 4; gk++) begin : g_kind
                assign cnt_d[gk] = (cons[gk] != '0) ? max_t(cnt_q[gk], cons[gk])
                                                    : dec_t(cnt_q[gk]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cmd_counter[gi] = cnt_q;
        end

`ifdef TFAW_TRACK_EN
        for (gi = 0; gi < NUM_RNK_TOT; gi++) begin : g_faw
            localparam logic [RANK_W-1:0] MY_RANK = RANK_W'(gi);

            logic                         act_here;
            logic [3:0][TIME_WIDTH-1:0]   slot_q, slot_d;
            logic [1:0]                   ptr_q, ptr_d;

            assign act_here = cmd_act && (issue_rank == MY_RANK);

            // ptr always addresses the oldest ACT, which the next ACT overwrites.
            for (gk = 0; gk < 4; gk++) begin : g_slot
                assign slot_d[gk] = (act_here && (ptr_q == 2'(gk))) ? t_faw
                                                                    : dec_t(slot_q[gk]);
            end
            assign ptr_d = act_here ? ptr_q + 2'd1 : ptr_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_q <= '0;
                    ptr_q  <= '0;
                end else begin
                    slot_q <= slot_d;
                    ptr_q  <= ptr_d;
                end
            end

            assign tfaw_valid[gi]   = (slot_q[0] != '0) && (slot_q[1] != '0) &&
                                      (slot_q[2] != '0) && (slot_q[3] != '0);
            assign tfaw_counter[gi] = slot_q[ptr_q];
        end
`else
        logic unused_tfaw;
        assign unused_tfaw  = ^t_faw;
        assign tfaw_valid   = '0;
        assign tfaw_counter = '0;
`endif
    endgenerate

endmodule
